// File: rtl/comb_1.sv
// rtl/comb_1.sv - lamp-control function L = (D & X) | A with registered copy and saturating true-cycle counter
module comb_1 #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               D,
    input  logic               X,
    input  logic               A,
    output logic               L_comb,
    output logic               L,
    output logic [COUNT_W-1:0] L_cnt
);

    logic f;

    // A overrides the D/X qualifier pair.
    assign f      = (D & X) | A;
    assign L_comb = f;

    always_ff @(posedge clk) begin
        if (rst) begin
            L     <= 1'b0;
            L_cnt <= '0;
        end else begin
            L <= f;
            // Saturate at all-ones so a long-true condition never wraps to a small count.
            if (f && (L_cnt != {COUNT_W{1'b1}})) begin
                L_cnt <= L_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_comb_1.sv
// tb/tb_comb_1.sv - self-checking bench for comb_1 with a counting reference model
module tb_comb_1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       D = 1'b0;
    logic       X = 1'b0;
    logic       A = 1'b0;
    logic       L_comb, L, L_comb3, L3;
    logic [7:0] L_cnt;
    logic [2:0] L_cnt3;

    int checks = 0;
    int errors = 0;

    int m_l    = 0;
    int m_cnt  = 0;
    int m_cnt3 = 0;

    comb_1 #(.COUNT_W(8)) dut (
        .clk(clk), .rst(rst), .D(D), .X(X), .A(A),
        .L_comb(L_comb), .L(L), .L_cnt(L_cnt)
    );

    comb_1 #(.COUNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .D(D), .X(X), .A(A),
        .L_comb(L_comb3), .L(L3), .L_cnt(L_cnt3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lamp(input int d, input int x, input int a);
        return ((d == 1 && x == 1) || a == 1) ? 1 : 0;
    endfunction

    // Drive one vector shortly after an edge, check the combinational output,
    // then advance one edge and check both instances against the model.
    task automatic step(input int d, input int x, input int a, input int r);
        int f;
        D = d[0]; X = x[0]; A = a[0]; rst = r[0];
        f = lamp(d, x, a);
        #1;
        chk("L_comb", {31'd0, L_comb}, f);
        @(posedge clk);
        if (r == 1) begin
            m_l = 0; m_cnt = 0; m_cnt3 = 0;
        end else begin
            m_l = f;
            if (f == 1) begin
                if (m_cnt < 255) m_cnt = m_cnt + 1;
                if (m_cnt3 < 7) m_cnt3 = m_cnt3 + 1;
            end
        end
        #1;
        chk("L", {31'd0, L}, m_l);
        chk("L_cnt", {24'd0, L_cnt}, m_cnt);
        chk("L_cnt3", {29'd0, L_cnt3}, m_cnt3);
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Reset held with the override asserted.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
        chk("rst_L", {31'd0, L}, 0);
        chk("rst_cnt", {24'd0, L_cnt}, 0);
        chk("rst_comb", {31'd0, L_comb}, 1);
        step(0, 0, 1, 0);
        chk("rel_L", {31'd0, L}, 1);
        chk("rel_cnt", {24'd0, L_cnt}, 1);

        // Exhaustive sweep, each vector held for two edges.
        for (int v = 0; v < 8; v++) begin
            step((v >> 2) & 1, (v >> 1) & 1, v & 1, 0);
            step((v >> 2) & 1, (v >> 1) & 1, v & 1, 0);
        end

        // Counting from reset.
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        chk("count_cnt", {24'd0, L_cnt}, 5);
        chk("count_L", {31'd0, L}, 0);

        // Mid-run reset with the function true.
        step(1, 1, 1, 1);
        chk("mid_L", {31'd0, L}, 0);
        chk("mid_cnt", {24'd0, L_cnt}, 0);
        step(1, 1, 1, 0);
        chk("mid_rel_L", {31'd0, L}, 1);
        chk("mid_rel_cnt", {24'd0, L_cnt}, 1);

        // Glitch on X entirely between edges.
        step(1, 0, 0, 0);
        D = 1'b1; A = 1'b0; X = 1'b0;
        #1 chk("glitch_lo0", {31'd0, L_comb}, 0);
        X = 1'b1;
        #1 chk("glitch_hi", {31'd0, L_comb}, 1);
        X = 1'b0;
        #1 chk("glitch_lo1", {31'd0, L_comb}, 0);
        chk("glitch_L", {31'd0, L}, m_l);
        chk("glitch_cnt", {24'd0, L_cnt}, m_cnt);
        step(1, 0, 0, 0);

        // Saturation of the 3-bit counter.
        step(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0);
            chk("sat_cnt3", {29'd0, L_cnt3}, (i + 1 < 7) ? i + 1 : 7);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 1 : 0,
                 ($urandom_range(0, 31) == 0) ? 1 : 0);
        end

        // Long true run to drive the 8-bit counter into saturation.
        for (int i = 0; i < 260; i++) step(1, 1, $urandom_range(0, 1), 0);
        chk("sat_cnt8", {24'd0, L_cnt}, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comb_1.md
# comb_1

Three-input lamp-control logic block. It evaluates the Boolean function L = (D AND X) OR A over three single-bit condition inputs. It presents the result both combinationally and as a registered output, and counts the cycles in which the function is true. It sits between raw condition flags and downstream indicator/alarm logic that needs a glitch-free, clock-aligned signal.

## Interface
Parameters:
- COUNT_W, default 8: width of the true-cycle counter; legal range 1..32.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- D  input  1  condition input D.
- X  input  1  condition input X.
- A  input  1  condition input A (override; forces the function true).
- L_comb  output  1  unregistered function value, (D & X) | A.
- L  output  1  registered function value.
- L_cnt  output  COUNT_W  saturating count of clock edges at which the function was true.

## Operation
- Function f = (D & X) | A. Full truth table for (D,X,A) → f:
  - 000→0, 001→1, 010→0, 011→1
  - 100→0, 101→1, 110→1, 111→1
- L_comb = f at all times, including during reset. It is purely combinational and has no dependence on clk or rst.
- L register:
  - rising edge with rst=1: L ← 0.
  - rising edge with rst=0: L ← f, evaluated from D/X/A values present at that edge.
- L_cnt register:
  - rising edge with rst=1: L_cnt ← 0.
  - rising edge with rst=0 and f=1 and L_cnt < 2^COUNT_W−1: L_cnt ← L_cnt+1.
  - rising edge with rst=0 and f=1 and L_cnt = 2^COUNT_W−1: holds (saturates, no wrap).
  - rising edge with rst=0 and f=0: holds.
- Reset has priority over every other update. It is sampled only at clock edges; asserting rst between edges has no effect on L or L_cnt until the next edge.
- Unknown (X/Z) inputs are not required to be handled. Every input combination is legal; there are no illegal states.

## Timing
- L_comb: zero-cycle latency, combinational from D/X/A.
- L: one-cycle latency. L after edge k equals f of the inputs sampled at edge k.
- L_cnt: one-cycle latency. The count after edge k includes edge k's f.
- Reset values: L=0, L_cnt=0. L_comb is not reset; it reflects the inputs.
- Input changes between edges affect L_comb immediately and L/L_cnt only at the next edge.
- Reset mid-operation: at the first edge with rst=1, L and L_cnt clear regardless of f. At the first edge with rst=0 afterwards, normal evaluation resumes with no extra dead cycle.
- Simultaneous rst=1 and f=1 at the same edge: reset wins; L=0 and L_cnt=0.

## Test plan
- Exhaustive sweep: with rst=0, step (D,X,A) through 000..111 with each held for 2 clocks (10 ns clock, 20 ns per vector). L_comb must follow the truth table immediately. L must follow it one edge later (0,1,0,1,0,1,1,1).
- Reset: drive A=1 with rst=1 for 3 edges. Required: L=0, L_cnt=0, L_comb=1. Release rst; the next edge gives L=1, L_cnt=1.
- Counting: from reset, apply 110 for 5 edges then 100 for 3 edges. Required: L_cnt=5 and L=0 at the end.
- Saturation (COUNT_W=3): hold A=1 for 10 edges. Required: L_cnt reaches 7 after edge 7 and stays at 7.
- Mid-run reset: after the counting scenario (L_cnt=5), assert rst for one edge with D=X=A=1. Required: L=0, L_cnt=0. Deassert; the next edge gives L=1, L_cnt=1.
- Between-edge glitch: toggle X 0→1→0 while D=1, A=0, entirely between two edges. L_comb must pulse; L and L_cnt must stay unchanged.
